serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Control unit for the bit-serial subtractor datapath: the accumulator shift register, the cyclic addend shift register, the borrow flip-flop and the full subtractor. It takes a start request and sequences a parallel load, then one or more N-bit serial subtraction passes; the addend recirculates between passes. It clears the borrow between passes, captures the final borrow of every pass into a sticky underflow flag, and signals completion with a start/done handshake. It replaces the empty control logic in `top`, which instantiates it.

## Interface
- N, 4: word width; shift cycles per subtraction pass (N ≥ 2).
- RW, 4: width of the repetition count `Reps`.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- St  in  1  start request; level-sensitive, held until `Done`.
- Reps  in  RW  number of subtraction passes; sampled when a start is accepted.
- Bout  in  1  borrow-out of the full subtractor, combinational, for the current bit.
- L  out  1  load enable to both shift registers.
- Sh  out  1  right-shift enable, accumulator register.
- C  out  1  cyclic-shift enable, addend register.
- Bclr  out  1  borrow flip-flop clear, active high.
- Busy  out  1  high from the load cycle through the last shift cycle.
- Done  out  1  operation complete.
- Neg  out  1  sticky: a pass ended with borrow-out = 1, i.e. underflow.

## Operation
- Moore FSM with states IDLE, LOAD, SHIFT, CLR and DONE. All outputs are registered or decoded from state only.
- **IDLE**
  - Outputs are 0, except `Neg`, which holds its last value.
  - If `St=1`: latch `Reps` into the pass counter `rem`, clear `Neg`, and go to LOAD.
- **LOAD**
  - Assert `L=1` and `Bclr=1` for exactly 1 cycle.
  - If `rem==0`, go to DONE. Otherwise go to SHIFT with bit counter `bc=0`.
- **SHIFT**
  - Assert `Sh=C=1`. `bc` increments each cycle.
  - On the edge where `bc==N-1`: set `Neg` to `Neg | Bout` and decrement `rem`.
  - If the decremented `rem` is 0, go to DONE. Otherwise go to CLR.
- **CLR**
  - `Bclr=1` and `Sh=C=0` for 1 cycle; then go to SHIFT with `bc=0`.
  - The addend has rotated N positions and is therefore back in its original alignment.
- **DONE**
  - `Done=1`. Stay in DONE while `St=1`; go to IDLE when `St=0`.
  - This gives one operation per `St` assertion.
- **Field behaviour**
  - `bc` is ceil(log2 N) bits; it never exceeds N-1 and resets to 0 on each pass entry.
  - `rem` is RW bits and never underflows, because the zero check happens before decrement.
- `Busy` = state ∈ {LOAD, SHIFT, CLR}.
- `St` is ignored outside IDLE. A `Reps` change after acceptance has no effect.
- **Reset:** `RST_N=0` forces IDLE immediately, asynchronously, including mid-operation. `bc`, `rem`, `L`, `Sh`, `C`, `Bclr`, `Busy`, `Done` and `Neg` all go to 0.
  - Leaving reset with `St` already 1 starts an operation on the first edge after release.

## Timing
- Edge 0 is the edge at which `St=1` is sampled in IDLE.
- `L` is high in the cycle after edge 0.
- For a count R ≥ 1:
  - Pass k (k = 0..R-1) drives `Sh`/`C` high for N consecutive cycles, beginning after edge 1 + k(N+1).
  - A 1-cycle `Bclr` gap separates passes.
  - `Done` rises after edge 1 + RN + (R-1); total busy cycles = RN + R.
- R = 0: `Done` rises after edge 1; `Sh` and `C` are never asserted.
- `Bout` is sampled at the rising edge that ends each pass's last shift cycle.
- The datapath borrow flip-flop updates on the falling edge. `Bclr`, asserted for a full cycle, therefore clears it at the falling edge inside the LOAD or CLR cycle.
- Edge 0 to first `Sh` takes 1 cycle. `Done` to IDLE takes 1 cycle after `St` falls.

## Test plan
- **Single pass.** N=4, Reps=1, `St` high from edge 0 and held.
  - `L` high for cycle 1 only; `Sh=C=1` for cycles 2–5.
  - `Done` rises after edge 5 and holds.
  - After `St` drops, `Done` falls 1 cycle later.
- **Three passes.** N=4, Reps=3.
  - `Sh` pulses are 4 cycles wide, with `Bclr` high in the two gap cycles.
  - Exactly 12 `Sh` cycles total; `Done` after edge 15.
- **Zero passes.** Reps=0.
  - `L` for 1 cycle, then `Done`; zero `Sh` cycles; `Neg=0`.
- **Underflow flag.** N=4, Reps=2; drive `Bout=1` on the last bit of pass 1 only.
  - `Neg` is 1 at `Done`.
  - Repeat with `Bout=0` on both last bits → `Neg=0`.
  - `Neg` clears at the next start.
- **Mid-operation reset.** Pulse `RST_N=0` during pass 2, bit 1.
  - All outputs go to 0 without waiting for a clock edge; state IDLE.
  - A new start then runs a full, correct sequence.
- **Start handling.**
  - `St` toggled during SHIFT → no effect on sequencing.
  - `St` held through `Done` → no second operation until `St` goes 0 and then 1 again.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: sequencer for the bit-serial subtractor.
// Load, N-bit shift passes with borrow clear gaps, sticky underflow.
module serial_sub_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned RW = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          St,
  input  logic [RW-1:0] Reps,
  input  logic          Bout,
  output logic          L,
  output logic          Sh,
  output logic          C,
  output logic          Bclr,
  output logic          Busy,
  output logic          Done,
  output logic          Neg
);

  localparam int unsigned BW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CLR   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          neg_q, neg_d;
  logic          last_bit;

  assign last_bit = (bc_q == BW'(N - 1));

  // State, bit counter, pass counter and sticky flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bc_q    <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
    end
  end

  // Next-state logic; zero check on rem precedes any decrement
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (St) begin
          rem_d   = Reps;
          neg_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bc_d    = '0;
        state_d = (rem_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
          neg_d   = neg_q | Bout;
          rem_d   = rem_q - RW'(1);
          bc_d    = '0;
          state_d = (rem_q == RW'(1)) ? DONE : CLR;
        end else begin
          bc_d = bc_q + BW'(1);
        end
      end
      CLR: begin
        bc_d    = '0;
        state_d = SHIFT;
      end
      DONE: begin
        if (!St) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from state only
  always_comb begin
    L    = 1'b0;
    Sh   = 1'b0;
    C    = 1'b0;
    Bclr = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    unique case (state_q)
      LOAD: begin
        L    = 1'b1;
        Bclr = 1'b1;
        Busy = 1'b1;
      end
      SHIFT: begin
        Sh   = 1'b1;
        C    = 1'b1;
        Busy = 1'b1;
      end
      CLR: begin
        Bclr = 1'b1;
        Busy = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign Neg = neg_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed cycle-by-cycle check of the sequencer.
// Observed vector is {L,Sh,C,Bclr,Busy,Done,Neg}.
module tb_serial_sub_ctrl;

  localparam int N  = 4;
  localparam int RW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          St;
  logic [RW-1:0] Reps;
  logic          Bout;
  logic          L, Sh, C, Bclr, Busy, Done, Neg;

  int errs  = 0;
  int total = 0;
  int shc;
  logic neg_m;

  serial_sub_ctrl #(.N(N), .RW(RW)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .St   (St),
    .Reps (Reps),
    .Bout (Bout),
    .L    (L),
    .Sh   (Sh),
    .C    (C),
    .Bclr (Bclr),
    .Busy (Busy),
    .Done (Done),
    .Neg  (Neg)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {L, Sh, C, Bclr, Busy, Done, Neg};
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE: r passes, bm[p] is Bout on the
  // last bit of pass p; noise drives Bout=1 on the other bits;
  // tog drops St briefly in the first pass.
  task automatic run_op(input string tag, input int r,
                        input logic [15:0] bm, input logic noise,
                        input logic tog);
    Reps  = RW'(r);
    St    = 1'b1;
    Bout  = 1'b0;
    neg_m = 1'b0;
    shc   = 0;
    cyc();
    chk({tag, "_load"}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    Reps = ~RW'(r);
    cyc();
    for (int p = 0; p < r; p++) begin
      for (int b = 0; b < N; b++) begin
        chk({tag, "_shift"}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, neg_m});
        if (Sh) shc++;
        Bout = (b == N - 1) ? bm[p] : noise;
        if (tog && p == 0) St = (b != 1);
        cyc();
      end
      neg_m = neg_m | bm[p];
      Bout  = 1'b0;
      if (p < r - 1) begin
        chk({tag, "_clr"}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, neg_m});
        cyc();
      end
    end
    chk({tag, "_done"}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, neg_m});
    chk_int({tag, "_shcount"}, shc, r * N);
    cyc();
    chk({tag, "_hold1"}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, neg_m});
    cyc();
    chk({tag, "_hold2"}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, neg_m});
    St = 1'b0;
    cyc();
    chk({tag, "_idle"}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, neg_m});
    cyc();
    chk({tag, "_idle2"}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, neg_m});
  endtask

  initial begin
    RST_N = 1'b0;
    St    = 1'b0;
    Reps  = '0;
    Bout  = 1'b0;
    #12;
    chk("reset", 7'b0000000);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    chk("idle_no_st", 7'b0000000);

    run_op("single", 1, 16'h0000, 1'b0, 1'b0);
    run_op("three", 3, 16'h0000, 1'b0, 1'b1);
    run_op("zero", 0, 16'h0000, 1'b0, 1'b0);
    run_op("uflow", 2, 16'h0001, 1'b0, 1'b0);
    run_op("noflow", 2, 16'h0000, 1'b1, 1'b0);
    run_op("uflow2", 2, 16'h0002, 1'b0, 1'b0);

    Reps = 4'd3;
    St   = 1'b1;
    Bout = 1'b0;
    cyc();
    chk("mr_load", 7'b1001100);
    cyc();
    cyc();
    cyc();
    cyc();
    Bout = 1'b1;
    cyc();
    Bout = 1'b0;
    chk("mr_clr", 7'b0001101);
    cyc();
    cyc();
    chk("mr_p2b1", 7'b0110101);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mr_async", 7'b0000000);
    @(negedge CLK);
    RST_N = 1'b1;
    run_op("after_rst", 3, 16'h0004, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
